// File: rtl/hamming_pkg.sv
// Shared Hamming(7,4) definitions for the link encoder and decoder.
package hamming_pkg;

  localparam int unsigned CODE_W    = 7;
  localparam int unsigned DATA_W    = 4;
  localparam int unsigned SYN_W     = 3;
  localparam int unsigned BIT_CNT_W = 3;

  // Codeword bit indices (codeword position = index + 1)
  localparam int unsigned P1 = 0;
  localparam int unsigned P2 = 1;
  localparam int unsigned D0 = 2;
  localparam int unsigned P3 = 3;
  localparam int unsigned D1 = 4;
  localparam int unsigned D2 = 5;
  localparam int unsigned D3 = 6;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    DECODE  = 2'd1,
    HOLD    = 2'd2
  } state_t;

  // Syndrome value is the 1-based position of a single flipped bit, 0 when clean.
  function automatic logic [SYN_W-1:0] calc_syndrome(input logic [CODE_W-1:0] c);
    calc_syndrome = {c[P3] ^ c[D1] ^ c[D2] ^ c[D3],
                     c[P2] ^ c[D0] ^ c[D2] ^ c[D3],
                     c[P1] ^ c[D0] ^ c[D1] ^ c[D3]};
  endfunction

endpackage

// File: rtl/hamming_syndrome_corrector.sv
// Combinational syndrome computation and single-bit correction of a 7-bit codeword.
module hamming_syndrome_corrector
  import hamming_pkg::*;
(
  input  logic [CODE_W-1:0] code,
  output logic [SYN_W-1:0]  syndrome_c,
  output logic [DATA_W-1:0] data_c,
  output logic              corrected_c
);

  logic [CODE_W-1:0] flip_mask;
  logic [CODE_W-1:0] fixed;

  // Flip the bit the syndrome points at, then extract the data positions.
  always_comb begin
    syndrome_c = calc_syndrome(code);
    flip_mask  = '0;
    if (syndrome_c != '0) begin
      flip_mask = CODE_W'(1) << (syndrome_c - SYN_W'(1));
    end
    fixed       = code ^ flip_mask;
    data_c      = {fixed[D3], fixed[D2], fixed[D1], fixed[D0]};
    corrected_c = (syndrome_c != '0);
  end

endmodule

// File: rtl/hamming_serial_decoder.sv
// Bit-serial Hamming(7,4) receiver with valid/ready output and a saturating correction counter.
module hamming_serial_decoder
  import hamming_pkg::*;
#(
  parameter int unsigned CNT_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic              in_bit,
  input  logic              in_sof,
  output logic              in_ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [SYN_W-1:0]  out_syndrome,
  output logic              out_corrected,
  output logic              sync_err,
  input  logic              clr_count,
  output logic [CNT_W-1:0]  corr_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t               state;
  logic [BIT_CNT_W-1:0] bit_cnt;
  logic [CODE_W-1:0]    code_q;

  logic [SYN_W-1:0]     syndrome_c;
  logic [DATA_W-1:0]    data_c;
  logic                 corrected_c;

  hamming_syndrome_corrector u_corrector (
    .code        (code_q),
    .syndrome_c  (syndrome_c),
    .data_c      (data_c),
    .corrected_c (corrected_c)
  );

  // Input is accepted only while assembling a word.
  assign in_ready = (state == COLLECT);

  // Framing, decode registers, output handshake and correction counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= COLLECT;
      bit_cnt       <= '0;
      code_q        <= '0;
      out_valid     <= 1'b0;
      out_data      <= '0;
      out_syndrome  <= '0;
      out_corrected <= 1'b0;
      sync_err      <= 1'b0;
      corr_count    <= '0;
    end else begin
      sync_err <= 1'b0;
      case (state)
        COLLECT: begin
          if (in_valid) begin
            if (in_sof && (bit_cnt != '0)) begin
              // Resynchronise: drop the partial word, this bit becomes c0.
              code_q   <= CODE_W'(in_bit);
              bit_cnt  <= BIT_CNT_W'(1);
              sync_err <= 1'b1;
            end else begin
              for (int i = 0; i < CODE_W; i++) begin
                if (bit_cnt == BIT_CNT_W'(i)) code_q[i] <= in_bit;
              end
              if (bit_cnt == BIT_CNT_W'(CODE_W - 1)) begin
                bit_cnt <= '0;
                state   <= DECODE;
              end else begin
                bit_cnt <= bit_cnt + BIT_CNT_W'(1);
              end
            end
          end
        end
        DECODE: begin
          out_data      <= data_c;
          out_syndrome  <= syndrome_c;
          out_corrected <= corrected_c;
          out_valid     <= 1'b1;
          state         <= HOLD;
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= COLLECT;
          end
        end
        default: state <= COLLECT;
      endcase

      if (clr_count) begin
        corr_count <= '0;
      end else if ((state == DECODE) && corrected_c && (corr_count != CNT_MAX)) begin
        corr_count <= corr_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_hamming_serial_decoder.sv
// Self-checking bench for hamming_serial_decoder: vector table, corner sequences, random words.
module tb_hamming_serial_decoder;

  localparam int unsigned CNT_W   = 2;
  localparam int          CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_bit;
  logic             in_sof;
  logic             in_ready;
  logic             out_valid;
  logic             out_ready;
  logic [3:0]       out_data;
  logic [2:0]       out_syndrome;
  logic             out_corrected;
  logic             sync_err;
  logic             clr_count;
  logic [CNT_W-1:0] corr_count;

  int errors    = 0;
  int checks    = 0;
  int model_cnt = 0;

  typedef struct {
    logic [6:0] code;
    logic [3:0] data;
    logic [2:0] syn;
    logic       corr;
  } vec_t;

  vec_t vecs[7];

  always #5 clk = ~clk;

  hamming_serial_decoder #(.CNT_W(CNT_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_bit        (in_bit),
    .in_sof        (in_sof),
    .in_ready      (in_ready),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_data      (out_data),
    .out_syndrome  (out_syndrome),
    .out_corrected (out_corrected),
    .sync_err      (sync_err),
    .clr_count     (clr_count),
    .corr_count    (corr_count)
  );

  // Reference: a set bit at position p contributes p to an XOR sum; the sum is the syndrome.
  function automatic int pos_xor(input logic [6:0] c);
    int acc;
    acc = 0;
    for (int i = 0; i < 7; i++) if (c[i]) acc = acc ^ (i + 1);
    return acc;
  endfunction

  function automatic logic [6:0] encode(input logic [3:0] d);
    logic [6:0] c;
    int acc;
    c    = '0;
    c[2] = d[0];
    c[4] = d[1];
    c[5] = d[2];
    c[6] = d[3];
    acc  = pos_xor(c);
    c[0] = acc[0];
    c[1] = acc[1];
    c[3] = acc[2];
    return c;
  endfunction

  function automatic logic [3:0] model_data(input logic [6:0] c);
    logic [6:0] f;
    int s;
    f = c;
    s = pos_xor(c);
    if (s != 0) f[s-1] = ~f[s-1];
    return {f[6], f[5], f[4], f[2]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b, input logic sof, input logic exp_sync);
    in_valid = 1'b1;
    in_bit   = b;
    in_sof   = sof;
    chk("in_ready_collect", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    in_sof   = 1'b0;
    in_bit   = 1'b0;
    chk("sync_err", 32'(sync_err), 32'(exp_sync));
  endtask

  task automatic send_code(input logic [6:0] c, input int max_gap, input logic use_sof);
    for (int i = 0; i < 7; i++) begin
      repeat ($urandom_range(max_gap, 0)) begin
        in_bit = 1'($urandom);
        tick();
      end
      send_bit(c[i], use_sof && (i == 0), 1'b0);
    end
  endtask

  // Called right after the edge that accepted the seventh bit (DECODE cycle).
  task automatic expect_word(input logic [3:0] d, input logic [2:0] s, input logic corr,
                             input int hold, input logic clr_in_decode);
    chk("decode_out_valid", 32'(out_valid), 32'd0);
    chk("decode_in_ready", 32'(in_ready), 32'd0);
    clr_count = clr_in_decode;
    if (clr_in_decode) model_cnt = 0;
    else if (corr && model_cnt < CNT_MAX) model_cnt++;
    tick();
    clr_count = 1'b0;
    chk("out_valid", 32'(out_valid), 32'd1);
    chk("out_data", 32'(out_data), 32'(d));
    chk("out_syndrome", 32'(out_syndrome), 32'(s));
    chk("out_corrected", 32'(out_corrected), 32'(corr));
    chk("corr_count", 32'(corr_count), 32'(model_cnt));
    chk("hold_in_ready", 32'(in_ready), 32'd0);
    out_ready = 1'b0;
    for (int k = 0; k < hold; k++) begin
      in_valid = 1'b1;
      in_bit   = 1'($urandom);
      tick();
      chk("stall_valid", 32'(out_valid), 32'd1);
      chk("stall_data", 32'(out_data), 32'(d));
      chk("stall_syndrome", 32'(out_syndrome), 32'(s));
      chk("stall_corrected", 32'(out_corrected), 32'(corr));
      chk("stall_in_ready", 32'(in_ready), 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("release_valid", 32'(out_valid), 32'd0);
    chk("release_in_ready", 32'(in_ready), 32'd1);
  endtask

  // Watchdog so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [6:0] code;
    logic [6:0] ref_code;
    int p1;
    int p2;
    int nerr;

    vecs[0] = '{7'b1010101, 4'b1011, 3'd0, 1'b0};
    vecs[1] = '{7'b1000101, 4'b1011, 3'd5, 1'b1};
    vecs[2] = '{7'b0000001, 4'b0000, 3'd1, 1'b1};
    vecs[3] = '{7'b1010100, 4'b1011, 3'd1, 1'b1};
    vecs[4] = '{7'b0010101, 4'b1011, 3'd7, 1'b1};
    vecs[5] = '{7'b1111111, 4'b1111, 3'd0, 1'b0};
    vecs[6] = '{7'b1111110, 4'b1111, 3'd1, 1'b1};

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_bit    = 1'b0;
    in_sof    = 1'b0;
    out_ready = 1'b0;
    clr_count = 1'b0;
    tick();
    tick();
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_syndrome", 32'(out_syndrome), 32'd0);
    chk("rst_out_corrected", 32'(out_corrected), 32'd0);
    chk("rst_sync_err", 32'(sync_err), 32'd0);
    chk("rst_corr_count", 32'(corr_count), 32'd0);
    rst = 1'b0;

    // Table vectors; the second one is stalled for 10 cycles.
    for (int i = 0; i < 7; i++) begin
      send_code(vecs[i].code, 0, 1'(i % 2));
      expect_word(vecs[i].data, vecs[i].syn, vecs[i].corr, (i == 1) ? 10 : 0, 1'b0);
    end

    // Framing abort: three bits, then in_sof restarts the word.
    ref_code = 7'b1010101;
    send_bit(1'b1, 1'b1, 1'b0);
    send_bit(1'b0, 1'b0, 1'b0);
    send_bit(1'b1, 1'b0, 1'b0);
    send_bit(ref_code[0], 1'b1, 1'b1);
    for (int i = 1; i < 7; i++) send_bit(ref_code[i], 1'b0, 1'b0);
    expect_word(4'b1011, 3'd0, 1'b0, 0, 1'b0);

    // Reset four bits into a word, in the middle of a framed word.
    for (int i = 0; i < 4; i++) send_bit(1'($urandom), 1'b0, 1'b0);
    rst = 1'b1;
    tick();
    rst       = 1'b0;
    model_cnt = 0;
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_out_data", 32'(out_data), 32'd0);
    chk("midrst_corr_count", 32'(corr_count), 32'd0);
    code = encode(4'b0110);
    send_code(code, 0, 1'b0);
    expect_word(4'b0110, 3'd0, 1'b0, 0, 1'b0);

    // Counter: saturation, then clear colliding with a DECODE increment.
    clr_count = 1'b1;
    tick();
    clr_count = 1'b0;
    model_cnt = 0;
    chk("clr_count", 32'(corr_count), 32'd0);
    for (int w = 0; w < 4; w++) begin
      code = encode(4'(w + 3)) ^ (7'd1 << w);
      send_code(code, 1, 1'b1);
      expect_word(4'(w + 3), 3'(w + 1), 1'b1, 0, 1'b0);
    end
    chk("count_saturated", 32'(corr_count), 32'd3);
    code = encode(4'b1001) ^ 7'b0100000;
    send_code(code, 0, 1'b0);
    expect_word(4'b1001, 3'd6, 1'b1, 0, 1'b1);
    chk("count_clr_priority", 32'(corr_count), 32'd0);

    // Random words with 0, 1 or 2 bit errors, gaps, stalls and occasional clears.
    for (int w = 0; w < 60; w++) begin
      code = encode(4'($urandom));
      nerr = $urandom_range(2, 0);
      p1   = $urandom_range(6, 0);
      p2   = (p1 + 1 + $urandom_range(5, 0)) % 7;
      if (nerr >= 1) code[p1] = ~code[p1];
      if (nerr == 2) code[p2] = ~code[p2];
      send_code(code, 2, 1'($urandom));
      expect_word(model_data(code), 3'(pos_xor(code)), pos_xor(code) != 0,
                  $urandom_range(3, 0), $urandom_range(7, 0) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
